// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM encoding and timer register map.
// Used by apb_timer_master and by the timer's APB responder.
package apb_pkg;

    localparam int unsigned ST_W = 2;

    typedef logic [ST_W-1:0] apb_state_t;

    // Master FSM encoding; 2'b11 is unused and recovers to IDLE
    localparam apb_state_t IDLE   = 2'b00;
    localparam apb_state_t SETUP  = 2'b01;
    localparam apb_state_t ACCESS = 2'b10;

    // Timer register map
    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter for apb_timer_master.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; count saturates at LIMIT so it never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last permitted wait cycle reached
    assign expired_c = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_timer_master.sv
// APB3 initiator: single-command request/response to the timer register block.
// Optional ACCESS timeout enabled with `define APB_TIMEOUT_EN.
module apb_timer_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    import apb_pkg::*;

    apb_state_t state_q, state_d;

    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic accept_c;
    logic done_c;
    logic abort_c;

    assign cmd_ready = (state_q == IDLE) & ~PRESET;
    assign accept_c  = cmd_valid & cmd_ready;
    assign done_c    = (state_q == ACCESS) & PREADY;

`ifdef APB_TIMEOUT_EN
    logic wait_clr_c;
    logic wait_en_c;
    logic wait_expired_c;

    // Counter starts from zero on the first ACCESS cycle
    assign wait_clr_c = (state_q == SETUP);
    assign wait_en_c  = (state_q == ACCESS) & ~PREADY;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clr_i     (wait_clr_c),
        .en_i      (wait_en_c),
        .expired_c (wait_expired_c)
    );

    // PREADY in the final cycle wins over the abort
    assign abort_c = wait_en_c & wait_expired_c;
`else
    assign abort_c = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done_c || abort_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for APB drive and response registers
    always_comb begin
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    // Reads leave the previous write data on PWDATA
                    if (cmd_write) pwdata_d = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (done_c) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (abort_c) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // APB and response registers, synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_timer_master.sv
// Self-checking bench for apb_timer_master (directed + random transfers).
// Honours APB_TIMEOUT_EN when the design is built with it.
module tb_apb_timer_master;

    import apb_pkg::*;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 16;
    localparam int unsigned NRND = 40;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            waits;
        logic [DW-1:0] prd;
        logic          serr;
        bit            chain;
    } txn_t;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    int errors = 0;
    int checks = 0;

    // Transaction-level expectations
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic          m_pwrite;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    logic          m_tmo;

    txn_t rq[NRND+1];

    apb_timer_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic model_reset();
        m_paddr  = '0;
        m_pwdata = '0;
        m_pwrite = 1'b0;
        m_rdata  = '0;
        m_err    = 1'b0;
        m_tmo    = 1'b0;
    endtask

    function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int waits, input logic [DW-1:0] prd, input logic serr);
        txn_t t;
        t.w = w; t.a = a; t.d = d; t.waits = waits; t.prd = prd; t.serr = serr; t.chain = 1'b0;
        return t;
    endfunction

    task automatic present(input txn_t t);
        cmd_valid = 1'b1;
        cmd_write = t.w;
        cmd_addr  = t.a;
        cmd_wdata = t.d;
    endtask

    task automatic chk_bus(input string ph);
        chk({ph, "_psel"},    PSEL,    1);
        chk({ph, "_paddr"},   PADDR,   m_paddr);
        chk({ph, "_pwrite"},  PWRITE,  m_pwrite);
        chk({ph, "_pwdata"},  PWDATA,  m_pwdata);
        chk({ph, "_cmd_rdy"}, cmd_ready, 0);
        chk({ph, "_rsp_vld"}, rsp_valid, 0);
    endtask

    // One transfer: t already presented, DUT idle, called at a negedge.
    // With chain set, nx is presented right after acceptance and held.
    task automatic xfer(input txn_t t, input bit chain, input txn_t nx);
        int n_acc;
        bit tmo;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        tick();
        m_paddr  = t.a;
        m_pwrite = t.w;
        if (t.w) m_pwdata = t.d;
`ifdef APB_TIMEOUT_EN
        tmo   = (t.waits >= int'(TMO));
        n_acc = tmo ? int'(TMO) : t.waits + 1;
`else
        tmo   = 1'b0;
        n_acc = t.waits + 1;
`endif
        if (chain) begin
            present(nx);
        end else begin
            cmd_valid = 1'b0;
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
        end
        // Responder noise during SETUP must be ignored
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = DW'($urandom);
        #1;
        chk_bus("setup");
        chk("setup_penable", PENABLE, 0);
        chk("held_rdata", rsp_rdata, m_rdata);
        chk("held_err", rsp_err, m_err);
        chk("held_tmo", rsp_timeout, m_tmo);
        tick();
        for (int i = 0; i < n_acc; i++) begin
            PREADY  = (i == t.waits);
            PSLVERR = (i == t.waits) ? t.serr : 1'($urandom);
            PRDATA  = (i == t.waits) ? t.prd  : DW'($urandom);
            #1;
            chk_bus("access");
            chk("access_penable", PENABLE, 1);
            tick();
        end
        m_rdata = (tmo || t.w) ? '0 : t.prd;
        m_err   = tmo ? 1'b1 : t.serr;
        m_tmo   = tmo;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_timeout", rsp_timeout, m_tmo);
        chk("rsp_psel", PSEL, 0);
        chk("rsp_penable", PENABLE, 0);
        chk("rsp_cmd_ready", cmd_ready, 1);
        if (!chain) begin
            // PREADY in IDLE is ignored; response fields hold
            PREADY = 1'($urandom);
            tick();
            #1;
            chk("pulse_end", rsp_valid, 0);
            chk("idle_psel", PSEL, 0);
            chk("idle_hold_rdata", rsp_rdata, m_rdata);
            chk("idle_hold_paddr", PADDR, m_paddr);
            PREADY = 1'b0;
        end
    endtask

    initial begin
        txn_t t;
        txn_t none;
        none      = mk(1'b0, '0, '0, 0, '0, 1'b0);
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        model_reset();

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_tmo", rsp_timeout, 0);
        PRESET = 1'b0;
        tick();

        // Write TCR, zero wait states
        t = mk(1'b1, ADDR_TCR, 8'hA5, 0, 8'hEE, 1'b0);
        present(t); xfer(t, 1'b0, none);

        // Read TDR with three wait states
        t = mk(1'b0, ADDR_TDR, 8'h00, 3, 8'h3C, 1'b0);
        present(t); xfer(t, 1'b0, none);

        // Out-of-range read answered with PSLVERR
        t = mk(1'b0, 8'h05, 8'h00, 0, 8'h99, 1'b1);
        present(t); xfer(t, 1'b0, none);

        // Back-to-back: second command held during the first transfer
        t = mk(1'b1, ADDR_TSR, 8'h11, 2, 8'h00, 1'b0);
        none = mk(1'b0, ADDR_TCR, 8'h00, 1, 8'h77, 1'b0);
        present(t); xfer(t, 1'b1, none);
        xfer(none, 1'b0, none);

        // Reset during ACCESS with PREADY low
        t = mk(1'b0, ADDR_TSR, 8'h00, 0, 8'h00, 1'b0);
        present(t);
        #1;
        chk("rstx_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        tick();
        #1;
        chk("rstx_in_access", PENABLE, 1);
        PRESET = 1'b1;
        #1;
        chk("rstx_ready_low", cmd_ready, 0);
        tick();
        PRESET = 1'b0;
        model_reset();
        #1;
        chk("rstx_psel", PSEL, 0);
        chk("rstx_penable", PENABLE, 0);
        chk("rstx_rsp_valid", rsp_valid, 0);
        chk("rstx_paddr", PADDR, 0);
        chk("rstx_cmd_ready", cmd_ready, 1);
        tick();
        #1;
        chk("rstx_no_late_rsp", rsp_valid, 0);
        t = mk(1'b1, ADDR_TDR, 8'h5A, 1, 8'h00, 1'b0);
        present(t); xfer(t, 1'b0, none);

        // PREADY arrives in the last permitted wait cycle
        t = mk(1'b0, ADDR_TDR, 8'h00, TMO - 1, 8'hC3, 1'b0);
        present(t); xfer(t, 1'b0, none);

        // PREADY withheld past the timeout limit
        t = mk(1'b0, ADDR_TCR, 8'h00, TMO + 4, 8'h4B, 1'b0);
        present(t); xfer(t, 1'b0, none);

        // Random transfers, some chained back-to-back
        for (int i = 0; i <= int'(NRND); i++) begin
            rq[i] = mk(1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
                       int'($urandom_range(0, 4)), DW'($urandom), ($urandom_range(0, 3) == 0));
            rq[i].chain = (i < int'(NRND)) ? 1'($urandom) : 1'b0;
        end
        for (int i = 0; i < int'(NRND); i++) begin
            if (i == 0 || !rq[i-1].chain) present(rq[i]);
            xfer(rq[i], rq[i].chain, rq[i+1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
